// File: rtl/av_mul_scheduler.sv
// av_mul_scheduler
//   Shares one AV-multiply engine among NUM_REQ requesters (attention heads).
//   Arbitration is round-robin. The winner's per-column precision vector is
//   latched and sanitised at grant time, and the engine is launched. The
//   scheduler then waits for eng_done or a timeout, and the granted requester
//   receives a completion pulse.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req                 level request per requester, held until its req_done
//   req_prec            per-requester precision vectors, 2 bits per column
//   eng_start           one-cycle engine launch pulse
//   eng_precision_sel   latched precision vector for the active job
//   eng_done            engine completion pulse (only honoured in WAIT)
//   grant               one-hot owner of the engine, zero when idle
//   req_done            one-cycle completion pulse to the owner
//   req_err             coincident with req_done when the job timed out
//   busy                high whenever the FSM is not in IDLE
//   last_latency        WAIT-cycle count of the last completed job

// Per-column precision sanitiser: code 11 is unsupported by the engine and
// is demoted to FP16 (10).
module av_mul_prec_fix (
  input  logic [1:0] i_code,
  output logic [1:0] o_code
);
  assign o_code = (i_code == 2'b11) ? 2'b10 : i_code;
endmodule

module av_mul_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_COLS       = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LAT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*NUM_COLS*2-1:0] req_prec,
  output logic                        eng_start,
  output logic [NUM_COLS*2-1:0]       eng_precision_sel,
  input  logic                        eng_done,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        req_err,
  output logic                        busy,
  output logic [LAT_W-1:0]            last_latency
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PV_W  = NUM_COLS * 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LAUNCH   = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_winner, r_last_winner;
  logic [IDX_W-1:0]   w_pick, w_cand;
  logic               w_any;
  logic [PV_W-1:0]    r_prec, w_sel_prec, w_fix_prec;
  logic [LAT_W-1:0]   r_cnt, r_last_lat;
  logic               r_err;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_grant_oh;

  // Round-robin: scan from the slot after the previous winner, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last_winner) + 1 + i) % NUM_REQ);
      if (!w_any && req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  assign w_sel_prec = req_prec[int'(w_pick)*PV_W +: PV_W];

  genvar c;
  generate
    for (c = 0; c < NUM_COLS; c++) begin : g_col
      av_mul_prec_fix u_fix (
        .i_code (w_sel_prec[c*2 +: 2]),
        .o_code (w_fix_prec[c*2 +: 2])
      );
    end
  endgenerate

  assign w_timeout = (r_cnt == LAT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_any) w_state_nxt = S_LAUNCH;
      S_LAUNCH:   w_state_nxt = S_WAIT;
      S_WAIT:     if (eng_done || w_timeout) w_state_nxt = S_COMPLETE;
      S_COMPLETE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_winner      <= '0;
      r_last_winner <= IDX_W'(NUM_REQ - 1);
      r_prec        <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      r_last_lat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          // Winner and its precision are frozen here so req/req_prec
          // activity during the job cannot disturb it.
          if (w_any) begin
            r_winner <= w_pick;
            r_prec   <= w_fix_prec;
          end
        end
        S_LAUNCH: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        S_WAIT: begin
          // Counter is held on the exit cycle; the +1 is applied when the
          // latency is recorded so the exit cycle is included.
          if (eng_done)           r_err <= 1'b0;
          else if (w_timeout)     r_err <= 1'b1;
          else if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
        end
        S_COMPLETE: begin
          r_last_lat    <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          r_last_winner <= r_winner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_grant_oh = '0;
    w_grant_oh[r_winner] = 1'b1;
  end

  assign busy              = (r_state != S_IDLE);
  assign eng_start         = (r_state == S_LAUNCH);
  assign grant             = busy ? w_grant_oh : '0;
  assign req_done          = (r_state == S_COMPLETE) ? w_grant_oh : '0;
  assign req_err           = (r_state == S_COMPLETE) && r_err;
  assign eng_precision_sel = r_prec;
  assign last_latency      = r_last_lat;

endmodule
